ahb_sram_subordinate: RTL

AHB-Lite subordinate backed by a word-addressed SRAM array, with a configurable number of wait states. It sits directly downstream of the Vortex-to-AHB adapter and consumes its HSEL/HADDR/HTRANS/HSIZE/HWRITE/HWDATA beats. It returns HRDATA/HREADY/HRESP so that the adapter's 16-beat line transfers can be run in simulation and FPGA bring-up without an external memory.

---
 rtl/ahb_pkg.sv | 30 +++
 rtl/sram_word_array.sv | 26 ++
 rtl/ahb_sram_subordinate.sv | 136 +++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite transfer codes and subordinate FSM states.
// ERR1/ERR2 exist only with VX_AHB_SRAM_ERRCHK_EN defined.
package ahb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      BUSY   = 2'b01,
      NONSEQ = 2'b10,
      SEQ    = 2'b11
   } htrans_t;

   localparam logic [2:0] HSIZE_WORD  = 3'b010;
   localparam logic       HRESP_OKAY  = 1'b0;
   localparam logic       HRESP_ERROR = 1'b1;

`ifdef VX_AHB_SRAM_ERRCHK_EN
   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_ACCESS = 2'b01,
      S_ERR1   = 2'b10,
      S_ERR2   = 2'b11
   } sub_state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_ACCESS = 2'b01
   } sub_state_t;
`endif

endpackage

// File: rtl/sram_word_array.sv
// sram_word_array: MEM_WORDS x DATA_WIDTH storage,
// one synchronous write port and one combinational read port.
module sram_word_array #(
   parameter int DATA_WIDTH = 32,
   parameter int MEM_WORDS  = 4096,
   parameter int IDX_W      = $clog2(MEM_WORDS)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [IDX_W-1:0]      waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [IDX_W-1:0]      raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_sram_subordinate.sv
// ahb_sram_subordinate: AHB-Lite SRAM target with WAIT_STATES per beat.
// VX_AHB_SRAM_ERRCHK_EN enables range/alignment/HSIZE ERROR responses.
module ahb_sram_subordinate
   import ahb_pkg::*;
#(
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    MEM_WORDS   = 4096,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter int                    WAIT_STATES = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  HSEL,
   input  logic [ADDR_WIDTH-1:0] HADDR,
   input  logic [1:0]            HTRANS,
   input  logic [2:0]            HSIZE,
   input  logic                  HWRITE,
   input  logic [DATA_WIDTH-1:0] HWDATA,
   output logic [DATA_WIDTH-1:0] HRDATA,
   output logic                  HREADY,
   output logic                  HRESP
);

   localparam int IW = $clog2(MEM_WORDS);

   sub_state_t            state_q;
   sub_state_t            state_d;
   logic [3:0]            cnt_q;
   logic [3:0]            cnt_d;
   logic [IW-1:0]         idx_q;
   logic                  write_q;
   logic [ADDR_WIDTH-1:0] offset;
   logic                  legal;
   logic                  ready;
   logic                  resp;
   logic                  accept;
   logic                  done;
   logic                  we;
   logic [DATA_WIDTH-1:0] rd_word;
   logic                  unused;

   assign offset = HADDR - BASE_ADDR;

`ifdef VX_AHB_SRAM_ERRCHK_EN
   assign legal  = (offset[1:0] == 2'b00) &&
                   (offset[ADDR_WIDTH-1:IW+2] == '0) &&
                   (HSIZE == HSIZE_WORD);
   assign unused = HTRANS[0];
`else
   // Index wraps modulo MEM_WORDS; size and byte lane are ignored.
   assign legal  = 1'b1;
   assign unused = ^{HTRANS[0], HSIZE, offset[1:0],
                     offset[ADDR_WIDTH-1:IW+2]};
`endif

   always_comb begin
      ready = 1'b1;
      resp  = HRESP_OKAY;
      unique case (state_q)
         S_ACCESS: ready = (cnt_q == 4'd0);
`ifdef VX_AHB_SRAM_ERRCHK_EN
         S_ERR1: begin
            ready = 1'b0;
            resp  = HRESP_ERROR;
         end
         S_ERR2: resp = HRESP_ERROR;
`endif
         default: ;
      endcase
   end

   assign accept = reset && HSEL && HTRANS[1] && ready;
   assign done   = (state_q == S_ACCESS) && (cnt_q == 4'd0);
   assign we     = reset && done && write_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if ((state_q == S_ACCESS) && (cnt_q != 4'd0)) begin
         cnt_d = cnt_q - 4'd1;
      end
`ifdef VX_AHB_SRAM_ERRCHK_EN
      if (state_q == S_ERR1) begin
         state_d = S_ERR2;
      end
      if (ready) begin
         if (accept) state_d = legal ? S_ACCESS : S_ERR1;
         else        state_d = S_IDLE;
      end
`else
      if (ready) begin
         state_d = accept ? S_ACCESS : S_IDLE;
      end
`endif
      if (accept) begin
         cnt_d = 4'(WAIT_STATES);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         write_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            idx_q   <= offset[IW+1:2];
            write_q <= HWRITE;
         end
      end
   end

   sram_word_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .MEM_WORDS  (MEM_WORDS),
      .IDX_W      (IW)
   ) u_array (
      .clk   (clk),
      .we    (we),
      .waddr (idx_q),
      .wdata (HWDATA),
      .raddr (idx_q),
      .rdata (rd_word)
   );

   // Reset forces the idle bus response regardless of registered state.
   assign HREADY = !reset || ready;
   assign HRESP  = reset && resp;
   assign HRDATA = (reset && (state_q == S_ACCESS) && !write_q)
                 ? rd_word : '0;

endmodule
